// File: rtl/hazard_detection_unit_if.sv
// Bundle between the ID-stage pipeline and the hazard detection unit.
// stall_count exists only when HDU_PERF_CNT_EN is defined.
interface hazard_detection_unit_if #(
    parameter int CNT_W = 16
);
    logic       idex_memread;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       ifid_uses_rt;
    logic       branch_taken;
    logic       Hazard_Source;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

`ifdef HDU_PERF_CNT_EN
    logic [CNT_W-1:0] stall_count;

    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken,
        input  Hazard_Source, pc_write, ifid_write, ifid_flush, stall_count
    );
    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken,
        output Hazard_Source, pc_write, ifid_write, ifid_flush, stall_count
    );
`else
    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken,
        input  Hazard_Source, pc_write, ifid_write, ifid_flush
    );
    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, branch_taken,
        output Hazard_Source, pc_write, ifid_write, ifid_flush
    );
`endif
endinterface

// File: rtl/hazard_detection_unit.sv
// Load-use stall / branch squash control for the ID stage of a 5-stage pipeline.
// Optional saturating bubble counter enabled by HDU_PERF_CNT_EN.
module hazard_detection_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    hazard_detection_unit_if.slave  hdu
);
    typedef enum logic {IDLE, HOLD} state_e;

    // HOLD covers the bubbles after the detection cycle, so it counts down from N-2.
    localparam logic [3:0] REM_INIT =
        (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 15) begin : g_bad_stall
        $error("LOAD_STALL_CYCLES must be in 1..15");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    state_e     state_q, state_d;
    logic [3:0] rem_q, rem_d;
    logic       hz;
    logic       bubble, pc_we, ifid_we, flush;

    assign hz = hdu.idex_memread && (hdu.idex_rt != 5'd0) &&
                ((hdu.idex_rt == hdu.ifid_rs) ||
                 (hdu.ifid_uses_rt && (hdu.idex_rt == hdu.ifid_rt)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        bubble  = 1'b0;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        flush   = 1'b0;
        // While in reset the defaults above let the rest of the pipeline reset freely.
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (hz) begin
                        bubble  = 1'b1;
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = HOLD;
                            rem_d   = REM_INIT;
                        end
                    end else begin
                        flush = hdu.branch_taken;
                    end
                end
                HOLD: begin
                    // Inputs are deliberately unused here: the front end is frozen.
                    bubble  = 1'b1;
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    if (rem_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - 4'd1;
                    end
                end
            endcase
        end
    end

    assign hdu.Hazard_Source = bubble;
    assign hdu.pc_write      = pc_we;
    assign hdu.ifid_write    = ifid_we;
    assign hdu.ifid_flush    = flush;

`ifdef HDU_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hdu.stall_count = cnt_q;
`endif
endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: a 1-cycle and a 3-cycle instance, table plus sequences.
module tb_hazard_detection_unit;
    logic clk;
    logic rst1, rst3;

    hazard_detection_unit_if #(.CNT_W(4))  if1 ();
    hazard_detection_unit_if #(.CNT_W(16)) if3 ();

    hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut1 (
        .clk (clk),
        .rst (rst1),
        .hdu (if1)
    );
    hazard_detection_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut3 (
        .clk (clk),
        .rst (rst3),
        .hdu (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       mr;
        logic [4:0] xrt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urt;
        logic       br;
        logic [3:0] exp;   // {Hazard_Source, pc_write, ifid_write, ifid_flush}
    } vec_t;

    typedef struct {
        string       name;
        int          kind;  // 0/1: outputs of dut1/dut3, 2/3: stall_count of dut1/dut3
        logic [15:0] exp;
    } sb_t;

    localparam logic [3:0] RUN   = 4'b0110;
    localparam logic [3:0] STALL = 4'b1000;
    localparam logic [3:0] SQSH  = 4'b0111;

    sb_t  sbq[$];
    vec_t tbl[11];
    int   nchk = 0;
    int   nerr = 0;

    function automatic logic [15:0] actual(int kind);
        case (kind)
            0: return {12'd0, if1.Hazard_Source, if1.pc_write, if1.ifid_write, if1.ifid_flush};
            1: return {12'd0, if3.Hazard_Source, if3.pc_write, if3.ifid_write, if3.ifid_flush};
`ifdef HDU_PERF_CNT_EN
            2: return {12'd0, if1.stall_count};
            3: return if3.stall_count;
`endif
            default: return 16'hdead;
        endcase
    endfunction

    task automatic expect_out(string name, int kind, logic [15:0] exp);
        sbq.push_back('{name, kind, exp});
    endtask

    task automatic drv(int d, logic mr, logic [4:0] xrt, logic [4:0] rs, logic [4:0] rt,
                       logic urt, logic br);
        if (d == 1) begin
            if1.idex_memread = mr; if1.idex_rt = xrt; if1.ifid_rs = rs;
            if1.ifid_rt = rt; if1.ifid_uses_rt = urt; if1.branch_taken = br;
        end else begin
            if3.idex_memread = mr; if3.idex_rt = xrt; if3.ifid_rs = rs;
            if3.ifid_rt = rt; if3.ifid_uses_rt = urt; if3.branch_taken = br;
        end
    endtask

    // Compare everything queued this cycle mid-cycle, then advance to just past the next edge.
    task automatic tick();
        #4;
        while (sbq.size() > 0) begin
            sb_t         e;
            logic [15:0] a;
            e = sbq.pop_front();
            a = actual(e.kind);
            nchk++;
            if (a !== e.exp) begin
                nerr++;
                $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{"T1 rs load-use",       1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0, STALL};
        tbl[1]  = '{"T1 resume",            1'b0, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0, RUN};
        tbl[2]  = '{"T3 r0 no stall",       1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, RUN};
        tbl[3]  = '{"T3 rt unused",         1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, RUN};
        tbl[4]  = '{"rt used hazard",       1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, STALL};
        tbl[5]  = '{"no memread",           1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, RUN};
        tbl[6]  = '{"T4 hz beats flush",    1'b1, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, STALL};
        tbl[7]  = '{"T4 flush after stall", 1'b0, 5'd5, 5'd5, 5'd1, 1'b1, 1'b1, SQSH};
        tbl[8]  = '{"branch no match",      1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, SQSH};
        tbl[9]  = '{"back-to-back 1",       1'b1, 5'd9, 5'd2, 5'd9, 1'b1, 1'b0, STALL};
        tbl[10] = '{"back-to-back 2",       1'b1, 5'd9, 5'd9, 5'd2, 1'b0, 1'b0, STALL};

        // Reset: hazard and branch present, outputs must stay at pass-through values.
        rst1 = 1'b0;
        rst3 = 1'b0;
        drv(1, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
        drv(3, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
        expect_out("reset out dut1", 0, {12'd0, RUN});
        expect_out("reset out dut3", 1, {12'd0, RUN});
        tick();
        expect_out("reset hold dut1", 0, {12'd0, RUN});
        expect_out("reset hold dut3", 1, {12'd0, RUN});
`ifdef HDU_PERF_CNT_EN
        expect_out("reset cnt dut1", 2, 16'd0);
        expect_out("reset cnt dut3", 3, 16'd0);
`endif
        tick();

        // Table against the single-bubble instance (always IDLE between rows).
        rst1 = 1'b1;
        foreach (tbl[i]) begin
            drv(1, tbl[i].mr, tbl[i].xrt, tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].br);
            expect_out(tbl[i].name, 0, {12'd0, tbl[i].exp});
            tick();
        end
        drv(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst3 = 1'b1;
        drv(3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_out("idle dut1", 0, {12'd0, RUN});
        expect_out("idle dut3", 1, {12'd0, RUN});
`ifdef HDU_PERF_CNT_EN
        expect_out("table cnt dut1", 2, 16'd5);
`endif
        tick();

        // T2: three bubbles; X and branch inputs during HOLD are ignored.
        drv(3, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
        expect_out("T2 bubble 1", 1, {12'd0, STALL});
        tick();
        drv(3, 'x, 'x, 'x, 'x, 'x, 'x);
        expect_out("T2 bubble 2 x-in", 1, {12'd0, STALL});
        tick();
        drv(3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        expect_out("T2 bubble 3 br ign", 1, {12'd0, STALL});
        tick();
        drv(3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_out("T2 resume", 1, {12'd0, RUN});
`ifdef HDU_PERF_CNT_EN
        expect_out("T2 cnt", 3, 16'd3);
`endif
        tick();

        // T5: reset in the 2nd HOLD cycle.
        drv(3, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
        expect_out("T5 detect", 1, {12'd0, STALL});
        tick();
        expect_out("T5 hold 1", 1, {12'd0, STALL});
        tick();
        rst3 = 1'b0;
        expect_out("T5 rst forced", 1, {12'd0, RUN});
        tick();
        rst3 = 1'b1;
        drv(3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        expect_out("T5 idle after rst", 1, {12'd0, SQSH});
`ifdef HDU_PERF_CNT_EN
        expect_out("T5 cnt cleared", 3, 16'd0);
`endif
        tick();

        // Reset in the 1st HOLD cycle must abort the remaining bubbles.
        drv(3, 1'b1, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0);
        expect_out("mid-hold detect", 1, {12'd0, STALL});
        tick();
        rst3 = 1'b0;
        expect_out("mid-hold rst forced", 1, {12'd0, RUN});
        tick();
        rst3 = 1'b1;
        drv(3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        expect_out("mid-hold back idle", 1, {12'd0, SQSH});
        tick();

        // Fresh full stall after reset, branch coincident with detection.
        drv(3, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
        expect_out("restart bubble 1", 1, {12'd0, STALL});
        tick();
        expect_out("restart bubble 2", 1, {12'd0, STALL});
        tick();
        expect_out("restart bubble 3", 1, {12'd0, STALL});
        tick();
        drv(3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
        expect_out("restart branch", 1, {12'd0, SQSH});
`ifdef HDU_PERF_CNT_EN
        expect_out("restart cnt", 3, 16'd3);
`endif
        tick();

        // T6: 15 more hazards on dut1 (20 total) saturate its 4-bit counter.
        for (int k = 0; k < 15; k++) begin
            drv(1, 1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0);
            expect_out($sformatf("T6 hazard %0d", k), 0, {12'd0, STALL});
            tick();
        end
        drv(1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        expect_out("T6 resume", 0, {12'd0, RUN});
`ifdef HDU_PERF_CNT_EN
        expect_out("T6 cnt saturated", 2, 16'd15);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
